cm0_dbg_ppb_slv: RTL and testbench

CM0_DBG_PPB_SLV -- requirements
Module: cm0_dbg_ppb_slv

---
 rtl/cm0_dbg_ppb_defs.sv | 52 +++++
 rtl/cm0_dbg_ppb_dec.sv | 41 ++++
 rtl/cm0_dbg_ppb_slv.sv | 120 ++++++++++++
 tb/tb_cm0_dbg_ppb_slv.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cm0_dbg_ppb_defs.sv
`default_nettype none
// ============================================================================
// Module   : cm0_dbg_ppb_defs (package)
// Brief    : Shared constants for the debug PPB breakpoint-unit slave:
//            register addresses, one-hot select bit positions, state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cm0_dbg_ppb_defs;

  // Register word addresses in the BPU region
  localparam logic [31:0] c_addr_ctrl  = 32'hE000_2000;
  localparam logic [31:0] c_addr_comp0 = 32'hE000_2008;
  localparam logic [31:0] c_addr_comp1 = 32'hE000_200C;
  localparam logic [31:0] c_addr_comp2 = 32'hE000_2010;
  localparam logic [31:0] c_addr_comp3 = 32'hE000_2014;

  // Bit positions inside the one-hot register select
  localparam int c_sel_ctrl  = 4;
  localparam int c_sel_comp0 = 3;
  localparam int c_sel_comp1 = 2;
  localparam int c_sel_comp2 = 1;
  localparam int c_sel_comp3 = 0;

  // Only 32-bit accesses are legal on these registers
  localparam logic [2:0] c_hsize_word = 3'b010;

  // Slave state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Which selects exist for a given comparator count / debug presence.
  // Comparator counts above 4 saturate at 4.
  function automatic logic [4:0] impl_mask(input int bkpt, input int dbg);
    logic [4:0] m;
    int         n;
    n = (bkpt > 4) ? 4 : ((bkpt < 0) ? 0 : bkpt);
    m = '0;
    if (dbg != 0 && n > 0) begin
      m[c_sel_ctrl] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (i < n) m[c_sel_comp0 - i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cm0_dbg_ppb_dec.sv
`default_nettype none
// ============================================================================
// Module   : cm0_dbg_ppb_dec
// Brief    : Combinational register decoder. Turns the word address inside
//            the BPU region into a one-hot select and a mapped flag, masked
//            by the comparator count configured through BKPT and DBG.
// Revision : 1.0 - initial release
// ============================================================================
module cm0_dbg_ppb_dec
  import cm0_dbg_ppb_defs::*;
#(
  parameter int BKPT = 4,
  parameter int DBG  = 1
) (
  input  logic [9:0] addr_word_i,
  output logic [4:0] sel_o,
  output logic       mapped_o
);

  localparam logic [4:0] c_mask = impl_mask(BKPT, DBG);

  logic [4:0] sel_raw;

  // Raw address match, later masked by the configured register set
  always_comb begin
    sel_raw = '0;
    case (addr_word_i)
      c_addr_ctrl[11:2]:  sel_raw[c_sel_ctrl]  = 1'b1;
      c_addr_comp0[11:2]: sel_raw[c_sel_comp0] = 1'b1;
      c_addr_comp1[11:2]: sel_raw[c_sel_comp1] = 1'b1;
      c_addr_comp2[11:2]: sel_raw[c_sel_comp2] = 1'b1;
      c_addr_comp3[11:2]: sel_raw[c_sel_comp3] = 1'b1;
      default:            sel_raw = '0;
    endcase
  end

  assign sel_o    = sel_raw & c_mask;
  assign mapped_o = |sel_o;

endmodule
`default_nettype wire

// File: rtl/cm0_dbg_ppb_slv.sv
`default_nettype none
// ============================================================================
// Module   : cm0_dbg_ppb_slv
// Brief    : AHB-Lite slave front-end for the breakpoint-unit registers in
//            the debug PPB. Zero-wait-state reads/writes, two-cycle ERROR
//            response for illegal accesses.
// Config   : CM0_DBG_PPB_ERR_EN - when defined, unmapped word accesses get an
//            ERROR response; otherwise they are read-as-zero/write-ignored.
// Revision : 1.0 - initial release
// ============================================================================
module cm0_dbg_ppb_slv
  import cm0_dbg_ppb_defs::*;
#(
  parameter int BKPT = 4,
  parameter int DBG  = 1
) (
  input  logic        dclk,
  input  logic        dbg_reset_n,
  input  logic        hsel_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  input  logic [31:0] haddr_i,
  input  logic        hready_i,
  input  logic [31:0] hwdata_i,
  output logic        hready_o,
  output logic        hresp_o,
  output logic [31:0] hrdata_o,
  output logic [4:0]  dsl_bpu_sels_o,
  output logic        dsl_ppb_write_o,
  output logic [31:0] slv_wdata_o,
  input  logic [31:0] bpu_hrdata_i
);

  state_t     state_q, state_d;
  logic [4:0] sel_q, sel_d;
  logic       write_q, write_d;
  logic       read_q, read_d;

  logic [4:0] dec_sel;
  logic       dec_mapped;
  logic       accept;
  logic       acc_err;

  // Address bits outside the decoded word index, and the SEQ/NONSEQ
  // distinction, do not influence this slave.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{haddr_i[31:12], haddr_i[1:0], htrans_i[0]};

  cm0_dbg_ppb_dec #(
    .BKPT (BKPT),
    .DBG  (DBG)
  ) u_dec (
    .addr_word_i (haddr_i[11:2]),
    .sel_o       (dec_sel),
    .mapped_o    (dec_mapped)
  );

  // Address-phase acceptance, error classification and next-state logic
  always_comb begin
    accept = hsel_i & htrans_i[1] & hready_i &
             ((state_q == ST_IDLE) | (state_q == ST_DATA));
`ifdef CM0_DBG_PPB_ERR_EN
    acc_err = (hsize_i != c_hsize_word) | ~dec_mapped;
`else
    acc_err = (hsize_i != c_hsize_word);
`endif
    state_d = ST_IDLE;
    sel_d   = '0;
    write_d = 1'b0;
    read_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (accept) begin
          if (acc_err) begin
            state_d = ST_ERR1;
          end else begin
            // Unmapped (RAZ/WI) accesses still take a data phase, all selects 0
            state_d = ST_DATA;
            sel_d   = dec_sel;
            write_d = hwrite_i & dec_mapped;
            read_d  = ~hwrite_i & dec_mapped;
          end
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      // Anything presented during the second error cycle is dropped
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data-phase flags, synchronous active-low reset
  always_ff @(posedge dclk) begin
    if (!dbg_reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      write_q <= write_d;
      read_q  <= read_d;
    end
  end

  // Outputs are forced to their idle values while reset is held so that a
  // transfer aborted by reset can never issue a register write.
  logic in_data;
  assign in_data         = (state_q == ST_DATA) & dbg_reset_n;
  assign dsl_bpu_sels_o  = sel_q & {5{dbg_reset_n}};
  assign dsl_ppb_write_o = write_q & dbg_reset_n;
  assign slv_wdata_o     = in_data ? hwdata_i : 32'h0;
  assign hrdata_o        = (in_data & read_q) ? bpu_hrdata_i : 32'h0;
  assign hready_o        = ~((state_q == ST_ERR1) & dbg_reset_n);
  assign hresp_o         = ((state_q == ST_ERR1) | (state_q == ST_ERR2)) & dbg_reset_n;

endmodule
`default_nettype wire

// File: tb/tb_cm0_dbg_ppb_slv.sv
`default_nettype none
// ============================================================================
// Module   : tb_cm0_dbg_ppb_slv
// Brief    : Self-checking bench for cm0_dbg_ppb_slv (BKPT = 2). A transaction
//            level model predicts every output each cycle; directed vectors
//            add literal expectations for the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cm0_dbg_ppb_slv;

  localparam int BKPT = 2;
`ifdef CM0_DBG_PPB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        dclk = 1'b0;
  logic        dbg_reset_n;
  logic        hsel_i;
  logic [1:0]  htrans_i;
  logic        hwrite_i;
  logic [2:0]  hsize_i;
  logic [31:0] haddr_i;
  logic        hready_i;
  logic [31:0] hwdata_i;
  logic        hready_o;
  logic        hresp_o;
  logic [31:0] hrdata_o;
  logic [4:0]  dsl_bpu_sels_o;
  logic        dsl_ppb_write_o;
  logic [31:0] slv_wdata_o;
  logic [31:0] bpu_hrdata_i;

  always #5 dclk = ~dclk;

  cm0_dbg_ppb_slv #(.BKPT(BKPT), .DBG(1)) dut (
    .dclk            (dclk),
    .dbg_reset_n     (dbg_reset_n),
    .hsel_i          (hsel_i),
    .htrans_i        (htrans_i),
    .hwrite_i        (hwrite_i),
    .hsize_i         (hsize_i),
    .haddr_i         (haddr_i),
    .hready_i        (hready_i),
    .hwdata_i        (hwdata_i),
    .hready_o        (hready_o),
    .hresp_o         (hresp_o),
    .hrdata_o        (hrdata_o),
    .dsl_bpu_sels_o  (dsl_bpu_sels_o),
    .dsl_ppb_write_o (dsl_ppb_write_o),
    .slv_wdata_o     (slv_wdata_o),
    .bpu_hrdata_i    (bpu_hrdata_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Register map: -1 when unmapped, else the select bit position.
  function automatic int map_idx(input logic [31:0] a);
    int          eff;
    int          n;
    logic [11:0] off;
    off = a[11:0];
    eff = (BKPT > 4) ? 4 : BKPT;
    if (off == 12'h000 && eff > 0) return 4;
    if (off >= 12'h008 && off <= 12'h014 && off[1:0] == 2'b00) begin
      n = (int'(off) - 8) / 4;
      if (n < eff) return 3 - n;
    end
    return -1;
  endfunction

  bit         m_data, m_wr, m_rd;
  int         m_err;          // error cycles still to be shown (2 = first)
  logic [4:0] m_sel;
  int         m_idx;
  bit         run_cmp = 1'b0;

  always @(posedge dclk) begin
    if (!dbg_reset_n) begin
      m_err = 0; m_data = 0; m_wr = 0; m_rd = 0; m_sel = '0;
    end else if (m_err > 0) begin
      m_err = m_err - 1; m_data = 0; m_wr = 0; m_rd = 0; m_sel = '0;
    end else if (hsel_i && htrans_i[1] && hready_i) begin
      m_idx = map_idx(haddr_i);
      if (hsize_i != 3'd2 || (ERR_EN && m_idx < 0)) begin
        m_err = 2; m_data = 0; m_wr = 0; m_rd = 0; m_sel = '0;
      end else begin
        m_data = 1;
        m_sel  = (m_idx >= 0) ? 5'(1 << m_idx) : 5'd0;
        m_wr   = hwrite_i && (m_idx >= 0);
        m_rd   = !hwrite_i && (m_idx >= 0);
      end
    end else begin
      m_data = 0; m_wr = 0; m_rd = 0; m_sel = '0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge dclk) begin
    if (run_cmp) begin
      if (!dbg_reset_n) begin
        check("cmp_rst_hready", {31'd0, hready_o}, 32'd1);
        check("cmp_rst_hresp",  {31'd0, hresp_o},  32'd0);
        check("cmp_rst_hrdata", hrdata_o,          32'd0);
        check("cmp_rst_sels",   {27'd0, dsl_bpu_sels_o}, 32'd0);
        check("cmp_rst_write",  {31'd0, dsl_ppb_write_o}, 32'd0);
        check("cmp_rst_wdata",  slv_wdata_o,       32'd0);
      end else begin
        check("cmp_hready", {31'd0, hready_o}, {31'd0, (m_err != 2)});
        check("cmp_hresp",  {31'd0, hresp_o},  {31'd0, (m_err != 0)});
        check("cmp_hrdata", hrdata_o, m_rd ? bpu_hrdata_i : 32'd0);
        check("cmp_sels",   {27'd0, dsl_bpu_sels_o}, {27'd0, m_sel});
        check("cmp_write",  {31'd0, dsl_ppb_write_o}, {31'd0, m_wr});
        check("cmp_wdata",  slv_wdata_o, m_data ? hwdata_i : 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic s, input logic [1:0] t, input logic w,
                       input logic [2:0] z, input logic [31:0] a, input logic [31:0] d);
    @(posedge dclk);
    #1;
    hsel_i = s; htrans_i = t; hwrite_i = w; hsize_i = z; haddr_i = a; hwdata_i = d;
  endtask

  task automatic idle_bus(input logic [31:0] d);
    drive(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, d);
  endtask

  logic [31:0] addrs [7];

  initial begin
    dbg_reset_n = 1'b0; hsel_i = 1'b0; htrans_i = 2'b00; hwrite_i = 1'b0;
    hsize_i = 3'd2; haddr_i = 32'h0; hready_i = 1'b1;
    hwdata_i = 32'hDEAD_BEEF; bpu_hrdata_i = 32'h1234_5678;
    repeat (3) @(posedge dclk);
    @(negedge dclk);
    check("rst_hready", {31'd0, hready_o}, 32'd1);
    check("rst_hresp",  {31'd0, hresp_o},  32'd0);
    check("rst_hrdata", hrdata_o, 32'd0);
    check("rst_sels",   {27'd0, dsl_bpu_sels_o}, 32'd0);
    check("rst_write",  {31'd0, dsl_ppb_write_o}, 32'd0);
    check("rst_wdata",  slv_wdata_o, 32'd0);
    run_cmp = 1'b1;
    @(posedge dclk); #1; dbg_reset_n = 1'b1;

    // Write CTRL
    drive(1'b1, 2'b10, 1'b1, 3'd2, 32'hE000_2000, 32'h0);
    idle_bus(32'h0000_0001);
    @(negedge dclk);
    check("wr_ctrl_sels",   {27'd0, dsl_bpu_sels_o}, 32'h10);
    check("wr_ctrl_write",  {31'd0, dsl_ppb_write_o}, 32'd1);
    check("wr_ctrl_wdata",  slv_wdata_o, 32'h0000_0001);
    check("wr_ctrl_hready", {31'd0, hready_o}, 32'd1);
    idle_bus(32'h0);
    @(negedge dclk);
    check("wr_ctrl_after_sels", {27'd0, dsl_bpu_sels_o}, 32'd0);

    // Read COMP0
    bpu_hrdata_i = 32'h4000_0101;
    drive(1'b1, 2'b10, 1'b0, 3'd2, 32'hE000_2008, 32'h0);
    idle_bus(32'h0);
    @(negedge dclk);
    check("rd_comp0_sels",   {27'd0, dsl_bpu_sels_o}, 32'h08);
    check("rd_comp0_hrdata", hrdata_o, 32'h4000_0101);
    check("rd_comp0_write",  {31'd0, dsl_ppb_write_o}, 32'd0);

    // Read COMP2, unimplemented with BKPT = 2
    drive(1'b1, 2'b10, 1'b0, 3'd2, 32'hE000_2010, 32'h0);
    idle_bus(32'h0);
    @(negedge dclk);
`ifdef CM0_DBG_PPB_ERR_EN
    check("unmap_err1_hready", {31'd0, hready_o}, 32'd0);
    check("unmap_err1_hresp",  {31'd0, hresp_o},  32'd1);
    idle_bus(32'h0);
    @(negedge dclk);
    check("unmap_err2_hready", {31'd0, hready_o}, 32'd1);
    check("unmap_err2_hresp",  {31'd0, hresp_o},  32'd1);
`else
    check("unmap_rd_sels",   {27'd0, dsl_bpu_sels_o}, 32'd0);
    check("unmap_rd_hrdata", hrdata_o, 32'd0);
    check("unmap_rd_hresp",  {31'd0, hresp_o}, 32'd0);
    check("unmap_rd_hready", {31'd0, hready_o}, 32'd1);
`endif
    idle_bus(32'h0);

    // Byte write to CTRL, then an address presented during ERR2
    drive(1'b1, 2'b10, 1'b1, 3'd0, 32'hE000_2000, 32'h0);
    idle_bus(32'h0000_00FF);
    @(negedge dclk);
    check("byte_err1_hready", {31'd0, hready_o}, 32'd0);
    check("byte_err1_hresp",  {31'd0, hresp_o},  32'd1);
    check("byte_err1_write",  {31'd0, dsl_ppb_write_o}, 32'd0);
    drive(1'b1, 2'b10, 1'b1, 3'd2, 32'hE000_2000, 32'h0000_00FF);
    @(negedge dclk);
    check("byte_err2_hready", {31'd0, hready_o}, 32'd1);
    check("byte_err2_hresp",  {31'd0, hresp_o},  32'd1);
    idle_bus(32'h0000_0055);
    @(negedge dclk);
    check("err2_addr_ignored_sels",  {27'd0, dsl_bpu_sels_o}, 32'd0);
    check("err2_addr_ignored_write", {31'd0, dsl_ppb_write_o}, 32'd0);

    // Back-to-back write COMP0, read COMP1
    drive(1'b1, 2'b10, 1'b1, 3'd2, 32'hE000_2008, 32'h0);
    drive(1'b1, 2'b11, 1'b0, 3'd2, 32'hE000_200C, 32'h0000_A5A5);
    @(negedge dclk);
    check("b2b_1_sels",  {27'd0, dsl_bpu_sels_o}, 32'h08);
    check("b2b_1_write", {31'd0, dsl_ppb_write_o}, 32'd1);
    check("b2b_1_wdata", slv_wdata_o, 32'h0000_A5A5);
    idle_bus(32'h0);
    @(negedge dclk);
    check("b2b_2_sels",  {27'd0, dsl_bpu_sels_o}, 32'h04);
    check("b2b_2_write", {31'd0, dsl_ppb_write_o}, 32'd0);

    // hready_i low: address not sampled
    drive(1'b1, 2'b10, 1'b1, 3'd2, 32'hE000_2000, 32'h0);
    hready_i = 1'b0;
    idle_bus(32'h0);
    hready_i = 1'b1;
    @(negedge dclk);
    check("hready_low_sels", {27'd0, dsl_bpu_sels_o}, 32'd0);

    // BUSY transfer: no select
    drive(1'b1, 2'b01, 1'b1, 3'd2, 32'hE000_2000, 32'h0);
    idle_bus(32'h0);
    @(negedge dclk);
    check("busy_sels", {27'd0, dsl_bpu_sels_o}, 32'd0);

    // Sweep of addresses, write then read back-to-back (model checks)
    addrs[0] = 32'hE000_2000; addrs[1] = 32'hE000_2004; addrs[2] = 32'hE000_2008;
    addrs[3] = 32'hE000_200C; addrs[4] = 32'hE000_2010; addrs[5] = 32'hE000_2014;
    addrs[6] = 32'hE000_2018;
    for (int i = 0; i < 7; i++) begin
      bpu_hrdata_i = 32'hB000_0000 + 32'(i);
      drive(1'b1, 2'b10, 1'b1, 3'd2, addrs[i], 32'h0);
      drive(1'b1, 2'b10, 1'b0, 3'd2, addrs[i], 32'hC000_0000 + 32'(i));
    end
    idle_bus(32'h0);
    idle_bus(32'h0);
    idle_bus(32'h0);

    // Reset asserted during a write data phase: no write issued
    drive(1'b1, 2'b10, 1'b1, 3'd2, 32'hE000_2000, 32'h0);
    idle_bus(32'h0000_1111);
    dbg_reset_n = 1'b0;
    @(negedge dclk);
    check("rst_in_data_write", {31'd0, dsl_ppb_write_o}, 32'd0);
    check("rst_in_data_sels",  {27'd0, dsl_bpu_sels_o}, 32'd0);
    @(posedge dclk); #1; dbg_reset_n = 1'b1;

    // Reset asserted during ERR1
    drive(1'b1, 2'b10, 1'b0, 3'd1, 32'hE000_2008, 32'h0);
    idle_bus(32'h0);
    @(negedge dclk);
    check("pre_rst_err1_hready", {31'd0, hready_o}, 32'd0);
    #1; dbg_reset_n = 1'b0;
    @(posedge dclk); #1; dbg_reset_n = 1'b1;
    @(negedge dclk);
    check("rst_err1_hready", {31'd0, hready_o}, 32'd1);
    check("rst_err1_hresp",  {31'd0, hresp_o},  32'd0);
    check("rst_err1_sels",   {27'd0, dsl_bpu_sels_o}, 32'd0);

    repeat (3) idle_bus(32'h0);
    @(negedge dclk);
    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
